// File: rtl/fifo_wr_arbiter.sv
// Round-robin write arbiter: shares one FIFO write port among NUM_REQ producers,
// granting each winner a burst of up to MAX_BURST words with back-pressure on fifo_full.
module fifo_wr_arbiter #(
    parameter int unsigned NUM_REQ    = 4,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned MAX_BURST  = 4
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [NUM_REQ-1:0]            req,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
    input  logic                          fifo_full,
    output logic                          fifo_wr,
    output logic [DATA_WIDTH-1:0]         fifo_w_data,
    output logic [NUM_REQ-1:0]            grant,
    output logic [NUM_REQ-1:0]            ack
);

    localparam int unsigned IdxW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int unsigned CntW = $clog2(MAX_BURST + 1);
    localparam logic [CntW-1:0] LastBeat = CntW'(MAX_BURST - 1);
    localparam logic [IdxW-1:0] LastIdx  = IdxW'(NUM_REQ - 1);

    typedef enum logic [0:0] {StIdle, StBurst} state_e;

    state_e              state_q, state_d;
    logic [NUM_REQ-1:0]  grant_q, grant_d;
    logic [IdxW-1:0]     last_idx_q, last_idx_d;
    logic [CntW-1:0]     beat_q, beat_d;
    logic [IdxW-1:0]     g_idx;
    logic [IdxW-1:0]     pick_idx;
    logic [IdxW-1:0]     cand;
    logic                pick_found;
    logic                granted_req;
    logic                xfer;
    logic [DATA_WIDTH-1:0] data_mux;

    always_comb begin
        g_idx = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant_q[i]) g_idx = IdxW'(i);
        end
    end

    // Search upward from the requester after the last one served, wrapping around.
    always_comb begin
        pick_idx   = '0;
        pick_found = 1'b0;
        cand       = '0;
        for (int unsigned k = 1; k <= NUM_REQ; k++) begin
            cand = IdxW'((32'(last_idx_q) + k) % NUM_REQ);
            if (!pick_found && req[cand]) begin
                pick_idx   = cand;
                pick_found = 1'b1;
            end
        end
    end

    always_comb begin
        data_mux = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant_q[i]) data_mux = data_mux | req_data[i*DATA_WIDTH +: DATA_WIDTH];
        end
    end

    // Reset suppresses the write strobe so nothing lands on the reset edge itself.
    assign granted_req = |(grant_q & req);
    assign xfer        = granted_req & ~fifo_full & ~reset;
    assign fifo_wr     = xfer;
    assign ack         = grant_q & req & {NUM_REQ{~fifo_full & ~reset}};
    assign fifo_w_data = data_mux;
    assign grant       = grant_q;

    always_comb begin
        state_d    = state_q;
        grant_d    = grant_q;
        last_idx_d = last_idx_q;
        beat_d     = beat_q;
        unique case (state_q)
            StIdle: begin
                if (pick_found) begin
                    grant_d = NUM_REQ'(1) << pick_idx;
                    beat_d  = '0;
                    state_d = StBurst;
                end
            end
            StBurst: begin
                if ((xfer && beat_q == LastBeat) || (!xfer && !granted_req)) begin
                    grant_d    = '0;
                    last_idx_d = g_idx;
                    beat_d     = '0;
                    state_d    = StIdle;
                end else if (xfer) begin
                    beat_d = beat_q + CntW'(1);
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= StIdle;
            grant_q    <= '0;
            last_idx_q <= LastIdx;
            beat_q     <= '0;
        end else begin
            state_q    <= state_d;
            grant_q    <= grant_d;
            last_idx_q <= last_idx_d;
            beat_q     <= beat_d;
        end
    end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Scoreboard bench for fifo_wr_arbiter: directed requester traffic, expected writes and
// grant order queued up front and checked by an independent monitor.
module tb_fifo_wr_arbiter;

    localparam int N  = 4;
    localparam int DW = 32;

    logic            clk = 1'b0;
    logic            reset;
    logic [N-1:0]    req;
    logic [N*DW-1:0] req_data;
    logic            fifo_full;
    logic            fifo_wr;
    logic [DW-1:0]   fifo_w_data;
    logic [N-1:0]    grant;
    logic [N-1:0]    ack;

    always #5 clk = ~clk;

    fifo_wr_arbiter #(
        .NUM_REQ    (N),
        .DATA_WIDTH (DW),
        .MAX_BURST  (4)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .req         (req),
        .req_data    (req_data),
        .fifo_full   (fifo_full),
        .fifo_wr     (fifo_wr),
        .fifo_w_data (fifo_w_data),
        .grant       (grant),
        .ack         (ack)
    );

    typedef struct {
        int            idx;
        logic [DW-1:0] data;
    } wr_t;

    wr_t           exp_wr[$];
    logic [N-1:0]  exp_grant[$];
    logic [DW-1:0] words[N][$];
    int            n_checks = 0;
    int            n_fail   = 0;

    // Single-requester timing, one entry per negedge after the words are loaded.
    logic [N-1:0] sg[10] = '{4'b0010, 4'b0010, 4'b0010, 4'b0010, 4'b0000,
                             4'b0010, 4'b0010, 4'b0010, 4'b0000, 4'b0000};
    logic         sw[10] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] expv);
        n_checks++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, expv, $time);
        end
    endtask

    task automatic load(input int r, input logic [DW-1:0] base, input int n);
        for (int j = 0; j < n; j++) words[r].push_back(base + DW'(j));
    endtask

    task automatic expect_wr(input int r, input logic [DW-1:0] base, input int n);
        wr_t e;
        for (int j = 0; j < n; j++) begin
            e.idx  = r;
            e.data = base + DW'(j);
            exp_wr.push_back(e);
        end
    endtask

    task automatic refresh();
        for (int i = 0; i < N; i++) begin
            req[i] = (words[i].size() != 0);
            req_data[i*DW +: DW] = req[i] ? words[i][0] : '0;
        end
    endtask

    // One clock: requesters whose ack was high before the edge advance to their next word.
    task automatic tick();
        logic [N-1:0] a;
        refresh();
        #3;
        a = ack;
        @(posedge clk);
        #1;
        for (int i = 0; i < N; i++) begin
            if (a[i] && words[i].size() != 0) void'(words[i].pop_front());
        end
        refresh();
        @(negedge clk);
    endtask

    // Monitor: checks every write against the scoreboard and every new grant against the order.
    initial begin
        logic [N-1:0] prev_g;
        wr_t          e;
        prev_g = '0;
        forever begin
            @(negedge clk);
            #2;
            chk("ack_at_most_one", DW'($countones(ack) <= 1), 1);
            chk("wr_matches_ack", DW'(fifo_wr), DW'(|ack));
            chk("wr_without_grant", DW'(fifo_wr && grant == '0), 0);
            if (fifo_wr) begin
                if (exp_wr.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_write: got data 0x%0h ack %b, expected no write",
                             fifo_w_data, ack);
                end else begin
                    e = exp_wr.pop_front();
                    chk("wr_data", fifo_w_data, e.data);
                    chk("wr_ack", DW'(ack), DW'(1) << e.idx);
                end
            end
            if (grant != prev_g && grant != '0) begin
                if (prev_g != '0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL grant_gap: got %b straight after %b, expected an idle cycle",
                             grant, prev_g);
                end
                if (exp_grant.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL grant_extra: got %b, expected no new grant", grant);
                end else begin
                    chk("grant_order", DW'(grant), DW'(exp_grant.pop_front()));
                end
            end
            prev_g = grant;
        end
    end

    initial begin
        reset     = 1'b1;
        fifo_full = 1'b0;
        req       = '0;
        req_data  = '0;

        // Reset held with everyone requesting, then continuous round-robin.
        load(0, 32'hC000_0000, 8);
        load(1, 32'hC100_0000, 4);
        load(2, 32'hC200_0000, 4);
        load(3, 32'hC300_0000, 4);
        exp_grant.push_back(4'b0001);
        exp_grant.push_back(4'b0010);
        exp_grant.push_back(4'b0100);
        exp_grant.push_back(4'b1000);
        exp_grant.push_back(4'b0001);
        expect_wr(0, 32'hC000_0000, 4);
        expect_wr(1, 32'hC100_0000, 4);
        expect_wr(2, 32'hC200_0000, 4);
        expect_wr(3, 32'hC300_0000, 4);
        expect_wr(0, 32'hC000_0004, 4);
        for (int c = 0; c < 2; c++) begin
            tick();
            chk("rst_grant", DW'(grant), 0);
            chk("rst_wr", DW'(fifo_wr), 0);
            chk("rst_ack", DW'(ack), 0);
            chk("rst_data", fifo_w_data, 0);
        end
        reset = 1'b0;
        tick();
        chk("first_grant", DW'(grant), 32'b0001);
        repeat (30) tick();
        chk("rr_drained", DW'(exp_wr.size()), 0);

        // Single requester, 6 words: a 4-word burst, one idle cycle, then 2 more.
        exp_grant.push_back(4'b0010);
        exp_grant.push_back(4'b0010);
        expect_wr(1, 32'h0000_00A0, 6);
        load(1, 32'h0000_00A0, 6);
        for (int c = 0; c < 10; c++) begin
            tick();
            chk("single_grant", DW'(grant), DW'(sg[c]));
            chk("single_wr", DW'(fifo_wr), DW'(sw[c]));
        end

        // Back-pressure after 2 writes of requester 0.
        exp_grant.push_back(4'b0001);
        expect_wr(0, 32'h0000_00B0, 4);
        load(0, 32'h0000_00B0, 4);
        repeat (3) tick();
        fifo_full = 1'b1;
        for (int k = 0; k < 3; k++) begin
            #1;
            chk("bp_wr", DW'(fifo_wr), 0);
            chk("bp_ack", DW'(ack), 0);
            chk("bp_grant", DW'(grant), 32'b0001);
            tick();
        end
        fifo_full = 1'b0;
        #1;
        chk("bp_resume_wr1", DW'(fifo_wr), 1);
        tick();
        chk("bp_resume_wr2", DW'(fifo_wr), 1);
        tick();
        chk("bp_release_grant", DW'(grant), 0);
        chk("bp_release_wr", DW'(fifo_wr), 0);

        // Early drop by requester 2 with 3 and 0 waiting: order must be 2, 3, 0.
        exp_grant.push_back(4'b0100);
        exp_grant.push_back(4'b1000);
        exp_grant.push_back(4'b0001);
        expect_wr(2, 32'h0000_00D0, 2);
        expect_wr(3, 32'h0000_00E0, 4);
        expect_wr(0, 32'h0000_00F0, 1);
        load(2, 32'h0000_00D0, 2);
        load(3, 32'h0000_00E0, 4);
        load(0, 32'h0000_00F0, 1);
        repeat (3) tick();
        chk("drop_grant_held", DW'(grant), 32'b0100);
        chk("drop_no_write", DW'(fifo_wr), 0);
        tick();
        chk("drop_released", DW'(grant), 0);
        tick();
        chk("drop_next_grant", DW'(grant), 32'b1000);
        repeat (12) tick();
        chk("drop_drained", DW'(exp_wr.size()), 0);

        // Reset after one write of a 4-word burst; remaining words retried from requester 0.
        exp_grant.push_back(4'b0001);
        exp_grant.push_back(4'b0001);
        exp_grant.push_back(4'b0010);
        expect_wr(0, 32'h5000_0000, 4);
        expect_wr(1, 32'h5100_0000, 1);
        load(0, 32'h5000_0000, 4);
        repeat (2) tick();
        reset = 1'b1;
        #1;
        chk("midrst_wr", DW'(fifo_wr), 0);
        chk("midrst_ack", DW'(ack), 0);
        tick();
        chk("midrst_grant", DW'(grant), 0);
        chk("midrst_wr_after", DW'(fifo_wr), 0);
        load(1, 32'h5100_0000, 1);
        reset = 1'b0;
        tick();
        chk("postrst_grant", DW'(grant), 32'b0001);
        repeat (12) tick();

        chk("wr_queue_empty", DW'(exp_wr.size()), 0);
        chk("grant_queue_empty", DW'(exp_grant.size()), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
